// File: rtl/seg_pkg.sv
// Shared types, decode table and helpers for the seven-segment scan driver.
package seg_pkg;

  typedef logic [6:0] seg7_t;  // {g,f,e,d,c,b,a}, active-high

  localparam int    MAX_DIGITS = 8;
  localparam seg7_t SEG_OFF    = 7'b000_0000;

  localparam seg7_t SEG7_ROM [16] = '{
    7'b011_1111, 7'b000_0110, 7'b101_1011, 7'b100_1111,
    7'b110_0110, 7'b110_1101, 7'b111_1101, 7'b000_0111,
    7'b111_1111, 7'b110_1111, 7'b111_0111, 7'b111_1100,
    7'b011_1001, 7'b101_1110, 7'b111_1001, 7'b111_0001
  };

  // Active-high one-hot of idx; all zeros when idx is not below n.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx, input int n);
    logic [MAX_DIGITS-1:0] r;
    r = '0;
    if (int'(idx) < n) r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-side bundle: scan controls and digit data in, pin drives out.
interface seg_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              seg;
  logic                    dp_out;
  logic                    frame_start;

  modport master (
    output en, load, digits, dp, blank,
    input  anode, seg, dp_out, frame_start
  );

  modport slave (
    input  en, load, digits, dp, blank,
    output anode, seg, dp_out, frame_start
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg7_t      seg
);
  assign seg = SEG7_ROM[nib];
endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with tear-free frame loading.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_DIV          = 50000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW   = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  seg_scan_mux_if.slave bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0]         CNT_MAX     = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0]         IDX_MAX     = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF   = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam seg7_t                 SEG_PIN_OFF = {7{SEG_ACTIVE_LOW}};

  logic [CW-1:0]         cnt, cnt_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic                  tick, wrap, in_range, armed;
  logic [DW-1:0]         pend_dig, act_dig, nx_dig;
  logic [NUM_DIGITS-1:0] pend_dp, act_dp, nx_dp;
  logic [NUM_DIGITS-1:0] pend_bl, act_bl, nx_bl;
  logic [NUM_DIGITS-1:0] lz, anode_hi;
  logic [MAX_DIGITS-1:0] hot_cur, hot_nx;
  logic                  unused_hot;
  logic [3:0]            nib;
  seg7_t                 dec_seg, seg_hi;
  logic                  dp_hi;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hot_cur  = onehot(3'(idx), NUM_DIGITS);
    in_range = |hot_cur;
    tick     = bus.en && (cnt == CNT_MAX);
    wrap     = tick && ((idx == IDX_MAX) || !in_range);
    cnt_nx   = cnt;
    if (bus.en) cnt_nx = tick ? '0 : cnt + 1'b1;
    idx_nx   = in_range ? idx : '0;
    if (tick) idx_nx = wrap ? '0 : idx + 1'b1;
  end

  // The digit lit after a wrap edge already belongs to the new frame.
  assign nx_dig = wrap ? pend_dig : act_dig;
  assign nx_dp  = wrap ? pend_dp  : act_dp;
  assign nx_bl  = wrap ? pend_bl  : act_bl;

`ifdef SEG_SCAN_LZB_EN
  logic run;
  always_comb begin
    run = 1'b1;
    lz  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run   = run && (nx_dig[4*i +: 4] == 4'h0) && !nx_dp[i];
      lz[i] = run;
    end
  end
`else
  assign lz = '0;
`endif

  assign nib = nx_dig[{idx_nx, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  assign hot_nx     = onehot(3'(idx_nx), NUM_DIGITS);
  assign unused_hot = ^hot_nx;
  assign anode_hi   = hot_nx[NUM_DIGITS-1:0];
  assign seg_hi     = (nx_bl[idx_nx] || lz[idx_nx]) ? SEG_OFF : dec_seg;
  assign dp_hi      = nx_dp[idx_nx] && !nx_bl[idx_nx];

  // NOTE: state updates use non-blocking assignments, and the small pending/active
  // digit registers are reset so the display starts dark with known contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt             <= '0;
      idx             <= '0;
      armed           <= 1'b1;
      pend_dig        <= '0;
      pend_dp         <= '0;
      pend_bl         <= '1;
      act_dig         <= '0;
      act_dp          <= '0;
      act_bl          <= '1;
      bus.anode       <= ANODE_OFF;
      bus.seg         <= SEG_PIN_OFF;
      bus.dp_out      <= SEG_ACTIVE_LOW;
      bus.frame_start <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      idx <= idx_nx;
      if (wrap) begin
        act_dig <= pend_dig;
        act_dp  <= pend_dp;
        act_bl  <= pend_bl;
      end
      if (bus.load) begin
        pend_dig <= bus.digits;
        pend_dp  <= bus.dp;
        pend_bl  <= bus.blank;
      end
      if (bus.en) begin
        armed           <= 1'b0;
        bus.anode       <= anode_hi ^ ANODE_OFF;
        bus.seg         <= seg_hi ^ SEG_PIN_OFF;
        bus.dp_out      <= dp_hi ^ SEG_ACTIVE_LOW;
        bus.frame_start <= wrap || armed;
      end else begin
        bus.anode       <= ANODE_OFF;
        bus.seg         <= SEG_PIN_OFF;
        bus.dp_out      <= SEG_ACTIVE_LOW;
        bus.frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised and directed bench for seg_scan_mux against a frame-level display model.
// Leading-zero blanking scenarios are compiled in when SEG_SCAN_LZB_EN is defined.
module tb_seg_scan_mux;
  localparam int ND = 4;
  localparam int CD = 3;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB_ON = 1'b1;
`else
  localparam bit LZB_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   chk_on = 1'b0;

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS       (ND),
    .CLK_DIV          (CD),
    .ANODE_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Hand-derived pin patterns (active-low) pinning the model.
  logic [3:0] scan_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] lit_a5c0 [4] = '{7'b1000000, 7'b1000110, 7'b0010010, 7'b0001000};
  logic [6:0] lit_1234 [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

  // Model state: scan position, pending/shown frames, expected pins.
  int            m_cnt, m_idx;
  bit            m_first;
  logic [3:0]    p_dig [ND];
  logic [3:0]    a_dig [ND];
  logic [ND-1:0] p_dp, a_dp, p_bl, a_bl;
  logic [ND-1:0] e_anode;
  logic [6:0]    e_seg;
  logic          e_dp, e_fs;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no event within bound, expected one", name);
  endtask

  // Digit i is dark under leading-zero blanking when it sits above the highest
  // digit that is nonzero or carries a decimal point.
  function automatic bit lz_dark(input int i);
    int top = 0;
    for (int j = 0; j < ND; j++)
      if (a_dig[j] != 4'h0 || a_dp[j]) top = j;
    return LZB_ON && (i > top);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    m_first = 1'b1;
    for (int i = 0; i < ND; i++) begin
      p_dig[i] = 4'h0;
      a_dig[i] = 4'h0;
    end
    p_dp = '0; a_dp = '0; p_bl = '1; a_bl = '1;
    e_anode = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
  endtask

  task automatic model_step();
    bit tick, wrap;
    tick = 1'b0;
    wrap = 1'b0;
    if (bus.en) begin
      tick  = (m_cnt == CD - 1);
      wrap  = tick && (m_idx == ND - 1);
      m_cnt = tick ? 0 : m_cnt + 1;
      if (tick) m_idx = (m_idx + 1) % ND;
    end
    if (wrap) begin
      a_dig = p_dig; a_dp = p_dp; a_bl = p_bl;
    end
    if (bus.load) begin
      for (int i = 0; i < ND; i++) p_dig[i] = bus.digits[4*i +: 4];
      p_dp = bus.dp;
      p_bl = bus.blank;
    end
    if (bus.en) begin
      e_fs    = wrap || m_first;
      m_first = 1'b0;
      e_anode = ~(ND'(1) << m_idx);
      e_seg   = (a_bl[m_idx] || lz_dark(m_idx)) ? 7'h7F : ~hex_tab[a_dig[m_idx]];
      e_dp    = ~(a_dp[m_idx] && !a_bl[m_idx]);
    end else begin
      e_fs = 1'b0; e_anode = '1; e_seg = 7'h7F; e_dp = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("anode",       32'(bus.anode),       32'(e_anode));
      check("seg",         32'(bus.seg),         32'(e_seg));
      check("dp_out",      32'(bus.dp_out),      32'(e_dp));
      check("frame_start", 32'(bus.frame_start), 32'(e_fs));
    end
  end

  task automatic wait_frame(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (e_fs) return;
    end
    timeout(name);
  endtask

  task automatic wait_pos(input string name, input int idx, input int cnt);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (m_idx == idx && (cnt < 0 || m_cnt == cnt)) return;
    end
    timeout(name);
  endtask

  task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] p, input logic [ND-1:0] b);
    bus.digits = d; bus.dp = p; bus.blank = b; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.digits = '0; bus.dp = '0; bus.blank = '0;
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_anode", 32'(bus.anode), 32'h0000000F);
    check("rst_seg",   32'(bus.seg),   32'h0000007F);
    check("rst_dp",    32'(bus.dp_out), 32'h1);
    check("rst_fs",    32'(bus.frame_start), 32'h0);

    // Scan order and frame pulse after release.
    bus.en = 1'b1;
    rst_n  = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check("scan_anode", 32'(bus.anode), 32'(scan_pat[(k / 3) % 4]));
      if (k == 1 || k == 12) check("scan_fs", 32'(bus.frame_start), 32'h1);
    end

    // Hex decode of a full frame.
    do_load(16'hA5C0, 4'h0, 4'h0);
    wait_frame("dec_wait");
    for (int k = 0; k < 12; k++) begin
      check("dec_seg", 32'(bus.seg), 32'(lit_a5c0[m_idx]));
      @(negedge clk);
    end

    // Load mid-frame: the rest of this frame keeps old values.
    wait_pos("tear_wait", 2, -1);
    do_load(16'h1234, 4'h0, 4'h0);
    for (int n = 0; n < 20 && !e_fs; n++) begin
      check("tear_old", 32'(bus.seg), 32'(lit_a5c0[m_idx]));
      @(negedge clk);
    end
    for (int k = 0; k < 12; k++) begin
      check("tear_new", 32'(bus.seg), 32'(lit_1234[m_idx]));
      @(negedge clk);
    end

    // Blanking and decimal point.
    do_load(16'h1234, 4'b0001, 4'b0100);
    wait_frame("bl_wait");
    for (int k = 0; k < 12; k++) begin
      check("bl_dp", 32'(bus.dp_out), (m_idx == 0) ? 32'h0 : 32'h1);
      if (m_idx == 2) begin
        check("bl_seg",   32'(bus.seg),   32'h7F);
        check("bl_anode", 32'(bus.anode), 32'b1011);
      end
      @(negedge clk);
    end

    // Enable hold and resume.
    wait_pos("en_wait", 1, 1);
    bus.en = 1'b0;
    @(negedge clk);
    check("en_anode", 32'(bus.anode),  32'hF);
    check("en_seg",   32'(bus.seg),    32'h7F);
    check("en_dp",    32'(bus.dp_out), 32'h1);
    repeat (9) @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    check("en_resume", 32'(bus.anode), 32'b1101);
    @(negedge clk);
    check("en_next",   32'(bus.anode), 32'b1011);

`ifdef SEG_SCAN_LZB_EN
    do_load(16'h0070, 4'h0, 4'h0);
    wait_frame("lzb_wait");
    for (int k = 0; k < 12; k++) begin
      check("lzb_seg", 32'(bus.seg),
            (m_idx >= 2) ? 32'h7F : (m_idx == 1) ? 32'b1111000 : 32'b1000000);
      @(negedge clk);
    end
    do_load(16'h0070, 4'b0100, 4'h0);
    wait_frame("lzb_dp_wait");
    for (int k = 0; k < 12; k++) begin
      check("lzb_dp_seg", 32'(bus.seg),
            (m_idx == 3) ? 32'h7F : (m_idx == 1) ? 32'b1111000 : 32'b1000000);
      check("lzb_dp_pin", 32'(bus.dp_out), (m_idx == 2) ? 32'h0 : 32'h1);
      @(negedge clk);
    end
`endif

    // Random traffic, checked every cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.en     = ($urandom_range(15) != 0);
      bus.load   = ($urandom_range(7) == 0);
      bus.digits = (4*ND)'($urandom);
      bus.dp     = ND'($urandom);
      bus.blank  = ($urandom_range(3) == 0) ? ND'($urandom) : '0;
      @(negedge clk);
    end
    bus.load = 1'b0;
    bus.en   = 1'b1;
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of a scan.
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_anode", 32'(bus.anode),       32'hF);
    check("mid_rst_seg",   32'(bus.seg),         32'h7F);
    check("mid_rst_fs",    32'(bus.frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_first_anode", 32'(bus.anode),       32'b1110);
    check("mid_rst_first_fs",    32'(bus.frame_start), 32'h1);
    repeat (20) @(negedge clk);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised time-multiplexed seven-segment display driver. It generalises the 4-digit rotating anode shifter to N digits.
- Adds a refresh prescaler, hex decoding, decimal points, per-digit blanking, tear-free frame-synchronous loading, an enable, and selectable output polarity.
- Sits between the numeric/status logic and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 2..8.
- CLK_DIV, 50000, clk cycles each digit stays lit; legal minimum 1.
- ANODE_ACTIVE_LOW, 1, 1 means the anode pins are driven low for the lit digit.
- SEG_ACTIVE_LOW, 1, 1 means the segment and dp pins are driven low for a lit segment.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; 0 turns the display dark and freezes the scan
- load  in  1  single-cycle request to capture the digit inputs into the pending registers
- digits  in  4*NUM_DIGITS  hex nibbles; digit i occupies bits [4i+3:4i]; digit 0 is the rightmost
- dp  in  NUM_DIGITS  decimal-point request per digit
- blank  in  NUM_DIGITS  1 forces that digit dark
- anode  out  NUM_DIGITS  one-hot digit select, polarity per ANODE_ACTIVE_LOW
- seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dp_out  out  1  decimal-point pin, polarity per SEG_ACTIVE_LOW
- frame_start  out  1  one-cycle pulse when digit 0 becomes lit

Behaviour:
- Clock and reset: clk is the only clock; reset is asynchronous, active-low, on rst_n.
- Reset state:
  - prescaler = 0, idx = 0.
  - Pending and active registers: digits = 0, dp = 0, blank = all 1s.
  - anode = all inactive; seg and dp_out = inactive; frame_start = 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 while en = 1; tick is asserted when the count equals CLK_DIV-1, and the count then wraps to 0.
  - With CLK_DIV = 1, tick is asserted every cycle.
  - Counter width is clog2(CLK_DIV), with a minimum of 1.
- Scan index:
  - On tick, idx goes from NUM_DIGITS-1 to 0, otherwise idx+1.
  - idx has no illegal values; any out-of-range idx is forced to 0.
- Load path:
  - When load = 1, digits, dp and blank are captured into the pending registers. A later load overwrites an earlier one.
  - The pending registers are copied into the active registers only on the tick that wraps idx to 0, so a frame never mixes old and new values.
  - A load on the wrap cycle itself misses that wrap; it takes effect at the next frame.
- Outputs:
  - All outputs are registered and change on the same edge as idx.
  - Latency: idx change to pin change is 0 cycles; load to visible is at most one frame plus one cycle.
  - anode = one-hot(idx) in active-high form, inverted if ANODE_ACTIVE_LOW = 1.
  - seg = hex decode of the active digit[idx]; dp_out = active dp[idx].
  - A blanked digit keeps its anode asserted and drives seg and dp_out inactive, so every digit keeps the same duty cycle.
- Hex decode (active-high form, gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- frame_start: 1 for exactly the cycle after the wrap edge; also 1 in the first cycle after reset release while en = 1.
- en:
  - When en = 0: on the next edge, anode, seg and dp_out go inactive; the prescaler and idx hold; load still captures into pending.
  - When en returns to 1, scanning resumes from the held idx and prescaler values.
- Reset mid-scan: all state returns to the reset values immediately; after release, digit 0 is scanned first.

Optional Feature:
- Macro: SEG_SCAN_LZB_EN.
- Defined: leading-zero blanking. Any digit that is 0 and has every higher-index digit also 0 is shown dark, except digit 0. A set dp on such a digit still lights dp_out and stops blanking of lower-index digits.
- Undefined: every digit shows its decoded value unless its blank bit is set.

Decomposition:
- Package seg_pkg:
  - SEG7_ROM: 16x7 constant array of decode patterns.
  - Active-high segment constant SEG_OFF.
  - Function onehot(idx, n).
  - Typedef seg7_t (7-bit).
- Sub-module hex_to_seg7: combinational nibble-to-seg7_t decode, instantiated once.
- The prescaler, index and load logic live in seg_scan_mux.

Test Plan:
- Reset and scan: NUM_DIGITS=4, CLK_DIV=3; release rst_n with en=1 → anode (active-low) cycles 1110, 1101, 1011, 0111, 3 cycles each; frame_start pulses every 12 cycles.
- Decode: load digits=16'hA5C0 with blank=0, then wait one frame → seg (active-low) is 1000000 for digit 0, 1000110 for digit 1, 0010010 for digit 2, 0001000 for digit 3.
- Tear-free load: load 16'h1234 while idx=2 → digits 2 and 3 still show the old values; new values appear from the next frame_start.
- Blank and dp: blank=4'b0100, dp=4'b0001 → digit 2 shows anode asserted with seg=1111111; dp_out=0 only while digit 0 is lit.
- Enable hold: drop en while idx=1 with prescaler=1 → all pins inactive next edge; restore en after 10 cycles → digit 1 lights with 1 remaining count.
- SEG_SCAN_LZB_EN defined: digits=16'h0070 → digits 3 and 2 dark, digits 1 and 0 show 7 and 0; with dp[2]=1 → digit 2 shows 0 with dp.
